// File: rtl/ahb_led_pwm.sv
// AHB-Lite LED peripheral: per-bit static or PWM drive from a shared prescaled 8-bit PWM.
// Registers: DATA, MODE, DUTY, PRESCALE; zero wait states, OKAY responses only.
`timescale 1ns/1ps
module ahb_led_pwm #(
    parameter logic [15:0] PRESCALE_RST = 16'd0,
    parameter int          ADDR_W       = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [7:0]        LED
);
    localparam int RW = ADDR_W - 2;
    localparam logic [RW-1:0] A_DATA     = RW'(0);
    localparam logic [RW-1:0] A_MODE     = RW'(1);
    localparam logic [RW-1:0] A_DUTY     = RW'(2);
    localparam logic [RW-1:0] A_PRESCALE = RW'(3);

    logic [RW-1:0] addr_q;
    logic          write_q;
    logic          valid_q;
    logic          wr_en;
    logic [7:0]    data_r;
    logic [7:0]    mode_r;
    logic [7:0]    duty_r;
    logic [15:0]   prescale_r;
    logic [15:0]   presc_cnt;
    logic [7:0]    pwm_cnt;
    logic          tick;
    logic          unused_ok;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign unused_ok = &{1'b0, HSIZE, HADDR[1:0], HWDATA[31:16]};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (HSEL && HREADY && HTRANS[1]) begin
            addr_q  <= HADDR[ADDR_W-1:2];
            write_q <= HWRITE;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign wr_en = valid_q && write_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_r     <= '0;
            mode_r     <= '0;
            duty_r     <= '0;
            prescale_r <= PRESCALE_RST;
        end else if (wr_en) begin
            case (addr_q)
                A_DATA:     data_r     <= HWDATA[7:0];
                A_MODE:     mode_r     <= HWDATA[7:0];
                A_DUTY:     duty_r     <= HWDATA[7:0];
                A_PRESCALE: prescale_r <= HWDATA[15:0];
                default:    ;
            endcase
        end
    end

    // A PRESCALE write restarts the prescale count so the new rate starts clean.
    assign tick = (presc_cnt == prescale_r);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            if (wr_en && (addr_q == A_PRESCALE)) begin
                presc_cnt <= '0;
            end else if (tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 16'd1;
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LED <= '0;
        end else begin
            LED <= (data_r & ~mode_r) | (data_r & mode_r & {8{pwm_cnt < duty_r}});
        end
    end

    always_comb begin
        HRDATA = '0;
        case (addr_q)
            A_DATA:     HRDATA = {24'd0, data_r};
            A_MODE:     HRDATA = {24'd0, mode_r};
            A_DUTY:     HRDATA = {24'd0, duty_r};
            A_PRESCALE: HRDATA = {16'd0, prescale_r};
            default:    HRDATA = '0;
        endcase
    end
endmodule

// File: tb/tb_ahb_led_pwm.sv
// Directed bench for ahb_led_pwm: register access, reset abort, static and PWM LED timing.
`timescale 1ns/1ps
module tb_ahb_led_pwm;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [3:0]  HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic        HREADY = 1'b1;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [7:0]  LED;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    ahb_led_pwm #(.PRESCALE_RST(16'd0), .ADDR_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .LED(LED)
    );

    // Returns #1 after the edge that commits the write.
    task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge CLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge CLK); #1;
    endtask

    task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
        @(posedge CLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge CLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge CLK);
        d = HRDATA;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_zero [4];
        exp_zero = '{32'd0, 32'd0, 32'd0, 32'd0};
        ahb_write(4'h0, 32'h0000_00FF);
        @(posedge CLK); @(negedge CLK);
        checks++;
        if (LED !== 8'hFF) begin errors++; $display("FAIL reset_pre_led got=%h exp=ff", LED); end
        @(posedge CLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 4'h0;
        @(posedge CLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h33;
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (LED !== 8'h00) begin errors++; $display("FAIL reset_async_led got=%h exp=00", LED); end
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            errors++; $display("FAIL reset_resp got=%b%b exp=10", HREADYOUT, HRESP);
        end
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ahb_read(4'(i * 4), rd);
            checks++;
            if (rd !== exp_zero[i]) begin errors++; $display("FAIL reset_reg%0d got=%h exp=%h", i, rd, exp_zero[i]); end
            checks++;
            if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
                errors++; $display("FAIL reset_resp_rd%0d got=%b%b exp=10", i, HREADYOUT, HRESP);
            end
        end
        checks++;
        if (LED !== 8'h00) begin errors++; $display("FAIL reset_post_led got=%h exp=00", LED); end
    endtask

    task automatic test_static();
        logic [31:0] rd;
        ahb_write(4'h4, 32'h0);
        ahb_write(4'h0, 32'hFFFF_FFA5);
        @(posedge CLK); @(negedge CLK);
        checks++;
        if (LED !== 8'hA5) begin errors++; $display("FAIL static_led got=%h exp=a5", LED); end
        ahb_read(4'h0, rd);
        checks++;
        if (rd !== 32'h0000_00A5) begin errors++; $display("FAIL static_read got=%h exp=000000a5", rd); end
    endtask

    task automatic test_back_to_back();
        @(posedge CLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 4'h8;
        @(posedge CLK); #1;
        HWDATA = 32'h0000_0040; HWRITE = 1'b0; HADDR = 4'h8;
        @(posedge CLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge CLK);
        checks++;
        if (HRDATA !== 32'h0000_0040) begin errors++; $display("FAIL b2b_read got=%h exp=00000040", HRDATA); end
    endtask

    task automatic test_idle_no_write();
        logic [31:0] rd;
        ahb_write(4'h0, 32'h3C);
        ahb_write(4'h4, 32'h00);
        @(posedge CLK); #1;
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 4'h0;
        @(posedge CLK); #1;
        HSEL = 1'b0; HWRITE = 1'b0; HWDATA = 32'hC3;
        @(posedge CLK); #1;
        HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 4'h0;
        @(posedge CLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h5A;
        @(posedge CLK); #1;
        HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 4'h4;
        @(posedge CLK); #1;
        HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hFF;
        ahb_read(4'h0, rd);
        checks++;
        if (rd !== 32'h3C) begin errors++; $display("FAIL idle_data got=%h exp=0000003c", rd); end
        ahb_read(4'h4, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL hsel0_mode got=%h exp=00000000", rd); end
    endtask

    task automatic test_pwm();
        int hi, upper_ok, mixed, t0, period;
        bit found;
        ahb_write(4'hC, 32'd0);
        ahb_write(4'h0, 32'hFF);
        ahb_write(4'h8, 32'd64);
        ahb_write(4'h4, 32'h0F);
        repeat (2) @(posedge CLK);
        hi = 0; upper_ok = 0; mixed = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            if (LED[3:0] == 4'hF) hi++;
            else if (LED[3:0] != 4'h0) mixed++;
            if (LED[7:4] == 4'hF) upper_ok++;
        end
        checks++;
        if (hi !== 64) begin errors++; $display("FAIL pwm_high got=%0d exp=64", hi); end
        checks++;
        if (mixed !== 0) begin errors++; $display("FAIL pwm_lockstep got=%0d exp=0", mixed); end
        checks++;
        if (upper_ok !== 256) begin errors++; $display("FAIL pwm_static_upper got=%0d exp=256", upper_ok); end
        found = 0; t0 = 0; period = 0;
        for (int i = 0; i < 1200; i++) begin
            logic prev;
            prev = LED[0];
            @(negedge CLK);
            if (!prev && LED[0]) begin
                if (found) begin period = i - t0; break; end
                found = 1; t0 = i;
            end
        end
        checks++;
        if (period !== 256) begin errors++; $display("FAIL pwm_period got=%0d exp=256", period); end
    endtask

    task automatic test_prescale();
        int hi, t0, period, n;
        bit found;
        logic prev;
        ahb_write(4'h0, 32'h01);
        ahb_write(4'h4, 32'h01);
        ahb_write(4'h8, 32'd128);
        ahb_write(4'hC, 32'd3);
        repeat (2) @(posedge CLK);
        hi = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge CLK);
            if (LED[0]) hi++;
        end
        checks++;
        if (hi !== 512) begin errors++; $display("FAIL presc_high got=%0d exp=512", hi); end
        found = 0; t0 = 0; period = 0;
        for (int i = 0; i < 4000; i++) begin
            prev = LED[0];
            @(negedge CLK);
            if (!prev && LED[0]) begin
                if (found) begin period = i - t0; break; end
                found = 1; t0 = i;
            end
        end
        checks++;
        if (period !== 1024) begin errors++; $display("FAIL presc_period got=%0d exp=1024", period); end
        // LED changes only one edge after a tick, and ticks fall every 4 edges from the rewrite.
        for (int k = 0; k < 2; k++) begin
            ahb_write(4'hC, 32'd3);
            prev = LED[0];
            n = 0;
            for (int i = 1; i <= 1200; i++) begin
                @(posedge CLK); #1;
                if (LED[0] != prev) begin n = i; break; end
            end
            checks++;
            if (n == 0 || (n % 4) != 1) begin
                errors++; $display("FAIL presc_restart%0d got=%0d edges exp=4k+1", k, n);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_duty_edges();
        int hi, lo;
        ahb_write(4'hC, 32'd0);
        ahb_write(4'h0, 32'hFF);
        ahb_write(4'h4, 32'h0F);
        ahb_write(4'h8, 32'd0);
        repeat (2) @(posedge CLK);
        hi = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge CLK);
            if (LED[3:0] != 4'h0) hi++;
        end
        checks++;
        if (hi !== 0) begin errors++; $display("FAIL duty0_high got=%0d exp=0", hi); end
        ahb_write(4'h8, 32'd255);
        repeat (2) @(posedge CLK);
        lo = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            if (LED[0] == 1'b0) lo++;
        end
        checks++;
        if (lo !== 1) begin errors++; $display("FAIL duty255_low got=%0d exp=1", lo); end
    endtask

    initial begin
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        test_reset();
        test_static();
        test_back_to_back();
        test_idle_no_write();
        test_pwm();
        test_prescale();
        test_duty_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
